// File: rtl/stopwatch_pkg.sv
// Shared types and seven-segment helpers for the BCD stopwatch.
// Segment patterns are active-high with segment a in bit 0 through g in bit 6.
package stopwatch_pkg;

   typedef logic [3:0] bcd_t;

   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;

   function automatic logic [6:0] seg_decode(input bcd_t i_bcd);
      logic [6:0] w_seg;
      case (i_bcd)
         4'd0:    w_seg = SEG_0;
         4'd1:    w_seg = SEG_1;
         4'd2:    w_seg = SEG_2;
         4'd3:    w_seg = SEG_3;
         4'd4:    w_seg = SEG_4;
         4'd5:    w_seg = SEG_5;
         4'd6:    w_seg = SEG_6;
         4'd7:    w_seg = SEG_7;
         4'd8:    w_seg = SEG_8;
         4'd9:    w_seg = SEG_9;
         default: w_seg = SEG_DASH;
      endcase
      return w_seg;
   endfunction

endpackage

// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment driver: a free-running divider advances the
// digit index and registers the active-low segment and anode outputs.
module seg_scan_mux
   import stopwatch_pkg::*;
#(
   parameter int unsigned DIGITS  = 4,
   parameter int unsigned MUX_DIV = 1024
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [4*DIGITS-1:0] i_shown,
   output logic [6:0]          o_seg_n,
   output logic [DIGITS-1:0]   o_an_n
);

   localparam int unsigned DW = $clog2(MUX_DIV);
   localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [DW-1:0]     r_div;
   logic [IW-1:0]     r_idx;
   logic [6:0]        r_seg_n;
   logic [DIGITS-1:0] r_an_n;
   logic              w_strobe;
   logic [IW-1:0]     w_idx_next;
   bcd_t              w_digit;

   assign w_strobe   = (r_div == DW'(MUX_DIV - 1));
   assign w_idx_next = (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
   // Data is registered for the index being advanced to, not the current one.
   assign w_digit    = i_shown[4*w_idx_next +: 4];

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_div   <= '0;
         r_idx   <= '0;
         r_seg_n <= 7'h7F;
         r_an_n  <= '1;
      end else if (w_strobe) begin
         r_div   <= '0;
         r_idx   <= w_idx_next;
         r_seg_n <= ~seg_decode(w_digit);
         r_an_n  <= ~(DIGITS'(1) << w_idx_next);
      end else begin
         r_div   <= r_div + DW'(1);
      end
   end

   assign o_seg_n = r_seg_n;
   assign o_an_n  = r_an_n;

endmodule

// File: rtl/stopwatch_bcd.sv
// N-digit BCD stopwatch with start/stop, lap-hold and clear, feeding a
// multiplexed seven-segment driver.
module stopwatch_bcd
   import stopwatch_pkg::*;
#(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned TICK_DIV = 800000,
   parameter int unsigned MUX_DIV  = 1024,
   parameter int unsigned LAP_HOLD = 20
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_start_stop,
   input  logic                i_lap,
   input  logic                i_clear,
   output logic                o_running,
   output logic [4*DIGITS-1:0] o_count,
   output logic [4*DIGITS-1:0] o_shown,
   output logic                o_overflow,
   output logic [6:0]          o_seg_n,
   output logic [DIGITS-1:0]   o_an_n
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam int unsigned HW = $clog2(LAP_HOLD + 1);

   logic                r_running;
   logic [PW-1:0]       r_presc;
   logic [4*DIGITS-1:0] r_count;
   logic [4*DIGITS-1:0] r_lap;
   logic [HW-1:0]       r_hold;
   logic                r_overflow;
   logic                w_tick;
   logic                w_carry;
   logic [4*DIGITS-1:0] w_count_inc;

   assign w_tick = r_running && (r_presc == PW'(TICK_DIV - 1));

   // Ripple BCD increment; w_carry surviving past the top digit means all-9s.
   always_comb begin
      w_carry     = 1'b1;
      w_count_inc = r_count;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (w_carry) begin
            if (r_count[4*i +: 4] == 4'd9) begin
               w_count_inc[4*i +: 4] = 4'd0;
            end else begin
               w_count_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
               w_carry               = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_clear) begin
         r_running  <= 1'b0;
         r_presc    <= '0;
         r_count    <= '0;
         r_lap      <= '0;
         r_hold     <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (i_start_stop) begin
            r_running <= ~r_running;
         end

         // Zero the prescaler on start so the first tick is a full period away.
         if (i_start_stop && !r_running) begin
            r_presc <= '0;
         end else if (r_running) begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
         end

         if (w_tick) begin
            r_count <= w_count_inc;
            if (w_carry) begin
               r_overflow <= 1'b1;
            end
         end

         if (i_lap) begin
            if (r_running) begin
               r_lap  <= r_count;
               r_hold <= HW'(LAP_HOLD);
            end else begin
               r_hold <= '0;
            end
         end else if (w_tick && (r_hold != '0)) begin
            r_hold <= r_hold - HW'(1);
         end
      end
   end

   assign o_running  = r_running;
   assign o_count    = r_count;
   assign o_overflow = r_overflow;
   assign o_shown    = (r_hold != '0) ? r_lap : r_count;

   seg_scan_mux #(
      .DIGITS  (DIGITS),
      .MUX_DIV (MUX_DIV)
   ) u_scan (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_shown (o_shown),
      .o_seg_n (o_seg_n),
      .o_an_n  (o_an_n)
   );

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd: a table of pulse/wait/expect records plus
// hand-written reset and display-scan sequences.
module tb_stopwatch_bcd;

   localparam int unsigned DIGITS   = 2;
   localparam int unsigned TICK_DIV = 4;
   localparam int unsigned MUX_DIV  = 2;
   localparam int unsigned LAP_HOLD = 3;

   logic        clk = 1'b0;
   logic        i_rst_n;
   logic        i_start_stop;
   logic        i_lap;
   logic        i_clear;
   logic        o_running;
   logic [7:0]  o_count;
   logic [7:0]  o_shown;
   logic        o_overflow;
   logic [6:0]  o_seg_n;
   logic [1:0]  o_an_n;

   always #5 clk = ~clk;

   stopwatch_bcd #(
      .DIGITS   (DIGITS),
      .TICK_DIV (TICK_DIV),
      .MUX_DIV  (MUX_DIV),
      .LAP_HOLD (LAP_HOLD)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (i_rst_n),
      .i_start_stop (i_start_stop),
      .i_lap        (i_lap),
      .i_clear      (i_clear),
      .o_running    (o_running),
      .o_count      (o_count),
      .o_shown      (o_shown),
      .o_overflow   (o_overflow),
      .o_seg_n      (o_seg_n),
      .o_an_n       (o_an_n)
   );

   typedef struct {
      string       name;
      logic        ss;
      logic        lap;
      logic        clr;
      int unsigned idle;
      logic        run;
      logic [7:0]  cnt;
      logic [7:0]  shw;
      logic        ovf;
   } vec_t;

   vec_t        vecs[$];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) edge_step();
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] prev_an;
      bit         found;

      // Each record: pulse inputs for one edge, wait idle edges, then expect
      // {running, count, shown, overflow}.
      vecs.push_back('{"start",        1'b1, 1'b0, 1'b0,   0, 1'b1, 8'h00, 8'h00, 1'b0});
      vecs.push_back('{"first_tick",   1'b0, 1'b0, 1'b0,   3, 1'b1, 8'h01, 8'h01, 1'b0});
      vecs.push_back('{"count_10",     1'b0, 1'b0, 1'b0,  35, 1'b1, 8'h10, 8'h10, 1'b0});
      vecs.push_back('{"count_99",     1'b0, 1'b0, 1'b0, 355, 1'b1, 8'h99, 8'h99, 1'b0});
      vecs.push_back('{"wrap",         1'b0, 1'b0, 1'b0,   3, 1'b1, 8'h00, 8'h00, 1'b1});
      vecs.push_back('{"clear_ovf",    1'b0, 1'b0, 1'b1,   0, 1'b0, 8'h00, 8'h00, 1'b0});
      vecs.push_back('{"restart",      1'b1, 1'b0, 1'b0,   0, 1'b1, 8'h00, 8'h00, 1'b0});
      vecs.push_back('{"reach_25",     1'b0, 1'b0, 1'b0,  99, 1'b1, 8'h25, 8'h25, 1'b0});
      vecs.push_back('{"lap_25",       1'b0, 1'b1, 1'b0,   0, 1'b1, 8'h25, 8'h25, 1'b0});
      vecs.push_back('{"hold_26",      1'b0, 1'b0, 1'b0,   2, 1'b1, 8'h26, 8'h25, 1'b0});
      vecs.push_back('{"hold_27",      1'b0, 1'b0, 1'b0,   3, 1'b1, 8'h27, 8'h25, 1'b0});
      vecs.push_back('{"hold_release", 1'b0, 1'b0, 1'b0,   3, 1'b1, 8'h28, 8'h28, 1'b0});
      vecs.push_back('{"lap_28",       1'b0, 1'b1, 1'b0,   0, 1'b1, 8'h28, 8'h28, 1'b0});
      vecs.push_back('{"hold_29",      1'b0, 1'b0, 1'b0,   2, 1'b1, 8'h29, 8'h28, 1'b0});
      vecs.push_back('{"stop_held",    1'b1, 1'b0, 1'b0,   0, 1'b0, 8'h29, 8'h28, 1'b0});
      vecs.push_back('{"lap_stopped",  1'b0, 1'b1, 1'b0,   0, 1'b0, 8'h29, 8'h29, 1'b0});
      vecs.push_back('{"stopped_idle", 1'b0, 1'b0, 1'b0,   7, 1'b0, 8'h29, 8'h29, 1'b0});
      vecs.push_back('{"clear2",       1'b0, 1'b0, 1'b1,   0, 1'b0, 8'h00, 8'h00, 1'b0});
      vecs.push_back('{"start3",       1'b1, 1'b0, 1'b0,   0, 1'b1, 8'h00, 8'h00, 1'b0});
      vecs.push_back('{"reach_07",     1'b0, 1'b0, 1'b0,  28, 1'b1, 8'h07, 8'h07, 1'b0});
      vecs.push_back('{"ss_lap",       1'b1, 1'b1, 1'b0,   0, 1'b0, 8'h07, 8'h07, 1'b0});
      vecs.push_back('{"hold_frozen",  1'b0, 1'b0, 1'b0,  10, 1'b0, 8'h07, 8'h07, 1'b0});
      vecs.push_back('{"resume",       1'b1, 1'b0, 1'b0,   0, 1'b1, 8'h07, 8'h07, 1'b0});
      vecs.push_back('{"hold_09",      1'b0, 1'b0, 1'b0,   7, 1'b1, 8'h09, 8'h07, 1'b0});
      vecs.push_back('{"hold_rel_10",  1'b0, 1'b0, 1'b0,   3, 1'b1, 8'h10, 8'h10, 1'b0});
      vecs.push_back('{"pre_tick",     1'b0, 1'b0, 1'b0,   2, 1'b1, 8'h10, 8'h10, 1'b0});
      vecs.push_back('{"clr_tick_ss",  1'b1, 1'b0, 1'b1,   0, 1'b0, 8'h00, 8'h00, 1'b0});
      vecs.push_back('{"cleared_idle", 1'b0, 1'b0, 1'b0,   5, 1'b0, 8'h00, 8'h00, 1'b0});
      vecs.push_back('{"start4",       1'b1, 1'b0, 1'b0,   0, 1'b1, 8'h00, 8'h00, 1'b0});
      vecs.push_back('{"pre_tick2",    1'b0, 1'b0, 1'b0,   2, 1'b1, 8'h00, 8'h00, 1'b0});
      vecs.push_back('{"stop_on_tick", 1'b1, 1'b0, 1'b0,   0, 1'b0, 8'h01, 8'h01, 1'b0});
      vecs.push_back('{"stopped2",     1'b0, 1'b0, 1'b0,   4, 1'b0, 8'h01, 8'h01, 1'b0});
      vecs.push_back('{"clear3",       1'b0, 1'b0, 1'b1,   0, 1'b0, 8'h00, 8'h00, 1'b0});
      vecs.push_back('{"start5",       1'b1, 1'b0, 1'b0,   0, 1'b1, 8'h00, 8'h00, 1'b0});
      vecs.push_back('{"reach_41",     1'b0, 1'b0, 1'b0, 166, 1'b1, 8'h41, 8'h41, 1'b0});
      vecs.push_back('{"stop_42",      1'b1, 1'b0, 1'b0,   0, 1'b0, 8'h42, 8'h42, 1'b0});

      i_rst_n      = 1'b0;
      i_start_stop = 1'b0;
      i_lap        = 1'b0;
      i_clear      = 1'b0;
      idle(3);
      i_rst_n = 1'b1;

      chk("reset_state", {o_running, o_count, o_shown, o_overflow},
          {1'b0, 8'h00, 8'h00, 1'b0});
      chk("reset_pins", {o_seg_n, o_an_n}, {7'h7F, 2'b11});
      idle(1);
      chk("pre_strobe_pins", {o_seg_n, o_an_n}, {7'h7F, 2'b11});
      // First strobe selects digit 1 showing 0.
      idle(1);
      chk("first_strobe_pins", {o_seg_n, o_an_n}, {7'h40, 2'b01});

      foreach (vecs[k]) begin
         i_start_stop = vecs[k].ss;
         i_lap        = vecs[k].lap;
         i_clear      = vecs[k].clr;
         edge_step();
         i_start_stop = 1'b0;
         i_lap        = 1'b0;
         i_clear      = 1'b0;
         idle(vecs[k].idle);
         chk(vecs[k].name, {o_running, o_count, o_shown, o_overflow},
             {vecs[k].run, vecs[k].cnt, vecs[k].shw, vecs[k].ovf});
      end

      // Display now holds 42: digit 0 = 2 (~5B = 24), digit 1 = 4 (~66 = 19).
      found   = 1'b0;
      prev_an = o_an_n;
      for (int i = 0; i < 20; i++) begin
         edge_step();
         if (prev_an == 2'b01 && o_an_n == 2'b10) begin
            found = 1'b1;
            break;
         end
         prev_an = o_an_n;
      end
      chk("scan_sync", {31'd0, found}, 32'd1);
      chk("scan_d0", {o_seg_n, o_an_n}, {7'h24, 2'b10});
      idle(1);
      chk("scan_d0_hold", {o_seg_n, o_an_n}, {7'h24, 2'b10});
      idle(1);
      chk("scan_d1", {o_seg_n, o_an_n}, {7'h19, 2'b01});
      idle(1);
      chk("scan_d1_hold", {o_seg_n, o_an_n}, {7'h19, 2'b01});
      idle(1);
      chk("scan_d0_again", {o_seg_n, o_an_n}, {7'h24, 2'b10});

      i_rst_n = 1'b0;
      edge_step();
      chk("midscan_reset_pins", {o_seg_n, o_an_n}, {7'h7F, 2'b11});
      chk("midscan_reset_state", {o_running, o_count, o_shown, o_overflow},
          {1'b0, 8'h00, 8'h00, 1'b0});
      i_rst_n = 1'b1;
      idle(1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/stopwatch_bcd.md
# stopwatch_bcd

Parametrised N-digit BCD stopwatch with start/stop, lap-hold and clear controls, and an integrated time-multiplexed seven-segment driver for DIGITS digits. It is the next generation of the board's 2-digit hex counter demo. It sits between the debounced button logic and the Pmod seven-segment pins, and replaces the free-running binary counter with a decimal, controllable, lap-capable timer.

## Interface
- DIGITS, 4: number of BCD digits, ≥1.
- TICK_DIV, 800000: clk cycles per count increment, ≥2.
- MUX_DIV, 1024: clk cycles per display digit slot, ≥2.
- LAP_HOLD, 20: ticks the lap value is held on the display, ≥1.
- clk  in  1  system clock, single clock domain.
- rst_n  in  1  synchronous reset, active-low.
- start_stop  in  1  single-cycle pulse; toggles running.
- lap  in  1  single-cycle pulse; captures the lap value.
- clear  in  1  single-cycle pulse; stops the timer and zeroes all state.
- running  out  1  timer is counting.
- count  out  4*DIGITS  live BCD count; digit 0 is in [3:0].
- shown  out  4*DIGITS  BCD value currently routed to the display.
- overflow  out  1  sticky; set on wrap from all-9s.
- seg_n  out  7  segments a..g in [0]..[6], active-low.
- an_n  out  DIGITS  digit enables, one-hot active-low.

## Operation
- Reset (rst_n=0 at clk edge): running=0, count=0, lap register=0, hold counter=0, overflow=0, prescaler=0, scan index=0, seg_n=7'h7F, an_n=all ones.
- Prescaler: counts only while running. When it reaches TICK_DIV-1 it returns to 0 and asserts the internal tick for one cycle. On a 0→1 transition of running, the prescaler is zeroed.
- Count: on tick, BCD increment with per-digit carry (9→0, carry into next digit). All-9s wraps to all-0s and sets overflow. Nibbles never hold values above 9.
- start_stop: running <= ~running. Count is retained on stop.
- lap: if running, the lap register <= count (the value before any same-cycle increment) and hold <= LAP_HOLD. If stopped, hold <= 0, which releases the display.
- Hold: decrements by 1 per tick while nonzero. shown = lap register when hold≠0, else count.
- clear: running=0, count=0, lap register=0, hold=0, overflow=0, prescaler=0. Scan state is unaffected.
- Priority within one cycle: rst_n > clear > (start_stop, lap, tick).
  - lap and start_stop together: lap is judged against running before the toggle.
  - tick and start_stop(stop) together: the increment still occurs.
  - tick and lap together: the lap captures the pre-increment count, and hold loads LAP_HOLD (no decrement that cycle).
- Display scan: a free-running divider strobes every MUX_DIV cycles. On each strobe the scan index advances modulo DIGITS, and segment/anode data are registered for the new index: an_n[i]=0 and seg_n=~decode(shown digit i).
- Decode for 0–9 uses standard segment patterns. Any non-BCD nibble decodes to the dash pattern (g only).

## Timing
- count and overflow update on the clk edge where tick=1 (one cycle after the prescaler reaches TICK_DIV-1).
- running, lap register and hold update one edge after their input pulse.
- shown is combinational from registers.
- seg_n/an_n are registered and change only on the edge following a scan strobe. Latency from a shown change to the pins is ≤ DIGITS*MUX_DIV+1 cycles.
- The first scan strobe after reset occurs at cycle MUX_DIV and drives digit 1 (for DIGITS=1, digit 0).
- Full refresh period = DIGITS*MUX_DIV cycles.
- Input pulses longer than one cycle are out of contract. A held start_stop toggles on every cycle.

## Structure
- Package stopwatch_pkg holds:
  - the BCD digit type (4 bits);
  - the seven-segment pattern constants for 0–9 and dash;
  - the function seg_decode(bcd) -> 7-bit active-high pattern.
- Sub-module seg_scan_mux (parameters DIGITS, MUX_DIV) contains the scan divider, index, and registered seg_n/an_n. The top block contains the prescaler, BCD counter, lap/hold and control logic.
- Widths: prescaler $clog2(TICK_DIV), scan divider $clog2(MUX_DIV), index $clog2(DIGITS) (min 1), hold $clog2(LAP_HOLD+1).

## Test plan
All scenarios use DIGITS=2, TICK_DIV=4, MUX_DIV=2, LAP_HOLD=3.
- Reset then start_stop pulse: running=1, and count reads 8'h01 after 4 cycles, 8'h10 after 40 cycles. seg_n/an_n are 7'h7F/2'b11 until the first strobe.
- Run to 8'h99, next tick: count=8'h00, overflow=1. A clear pulse then gives overflow=0, running=0, count=8'h00.
- lap at count 8'h25: shown=8'h25 for exactly 3 ticks while count advances, then shown=count. The same lap pulse issued while stopped does not capture and forces shown=count.
- start_stop and lap in the same cycle while running at 8'h07: the lap register holds 8'h07, running=0, hold=3, and shown stays 8'h07 because no ticks occur.
- clear asserted in the same cycle as tick and start_stop: count=0, running=0, no increment.
- Scan check: with count 8'h42 displayed, an_n alternates 2'b10/2'b01 every 2 cycles, seg_n=~pattern(2) with an_n=2'b10 and ~pattern(4) with an_n=2'b01. Asserting rst_n=0 mid-scan restores seg_n=7'h7F and an_n=2'b11 on the next edge.
